// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data memory arbiter: state encoding,
// port indices, latency counter width and the latched request record.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    // Wide enough for the full 0..15 latency range.
    localparam int CNT_W = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dm_req_t;

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner select for the two requesters.
// DATA_MEM_ARB_RR_EN selects round-robin on ties; otherwise port 0 has fixed priority.
module dm_arb_pick
    import dm_arb_pkg::*;
(
    input  logic port0_req,
    input  logic port1_req,
    input  logic last_grant,
    output logic grant
);

`ifdef DATA_MEM_ARB_RR_EN
    // On a tie the port that was not granted last time wins.
    always_comb begin
        grant = PORT_CORE;
        if (port0_req && port1_req)
            grant = ~last_grant;
        else if (port1_req)
            grant = PORT_DBG;
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = PORT_CORE;
        if (!port0_req && port1_req)
            grant = PORT_DBG;
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and access sequencer for the single data memory.
// Define DATA_MEM_ARB_RR_EN for round-robin tie breaking (default: fixed priority).
module data_mem_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Port0_req,
    input  logic        Port0_we,
    input  logic [31:0] Port0_addr,
    input  logic [31:0] Port0_wdata,
    output logic        Port0_done,
    output logic [31:0] Port0_rdata,
    input  logic        Port1_req,
    input  logic        Port1_we,
    input  logic [31:0] Port1_addr,
    input  logic [31:0] Port1_wdata,
    output logic        Port1_done,
    output logic [31:0] Port1_rdata,
    output logic        Data_mem_write_enable,
    output logic [31:0] Data_mem_write_addr,
    output logic [31:0] Data_mem_write_data,
    output logic        Data_mem_read_enable,
    output logic [31:0] Data_mem_read_addr,
    input  logic [31:0] Data_mem_read_data
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             grant_q, pick, last_grant, capture, any_req;
    dm_req_t          req_q, req_sel;

    assign any_req = Port0_req | Port1_req;

`ifdef DATA_MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!reset)
            last_grant <= PORT_DBG;
        else if (state == IDLE && any_req)
            last_grant <= pick;
    end
`else
    assign last_grant = PORT_DBG;
`endif

    dm_arb_pick u_pick (
        .port0_req  (Port0_req),
        .port1_req  (Port1_req),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_comb begin
        req_sel = '{we: Port0_we, addr: Port0_addr, wdata: Port0_wdata};
        if (pick == PORT_DBG)
            req_sel = '{we: Port1_we, addr: Port1_addr, wdata: Port1_wdata};
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Read data is sampled in ACCESS itself for zero latency, else on the last WAIT cycle.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE:   if (any_req) state_nxt = ACCESS;
            ACCESS: begin
                if (LAT == '0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt         <= '0;
            grant_q     <= PORT_CORE;
            req_q       <= '0;
            Port0_rdata <= '0;
            Port1_rdata <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant_q <= pick;
                req_q   <= req_sel;
            end
            if (state == ACCESS)
                cnt <= LAT;
            else if (state == WAIT)
                cnt <= cnt - 1'b1;
            if (capture && !req_q.we) begin
                if (grant_q == PORT_DBG)
                    Port1_rdata <= Data_mem_read_data;
                else
                    Port0_rdata <= Data_mem_read_data;
            end
        end
    end

    assign Data_mem_write_enable = (state == ACCESS) &&  req_q.we;
    assign Data_mem_read_enable  = (state == ACCESS) && !req_q.we;
    assign Data_mem_write_addr   = req_q.addr;
    assign Data_mem_write_data   = req_q.wdata;
    assign Data_mem_read_addr    = req_q.addr;

    // A DONE cycle that coincides with reset is an aborted access, so no pulse.
    assign Port0_done = reset && (state == DONE) && (grant_q == PORT_CORE);
    assign Port1_done = reset && (state == DONE) && (grant_q == PORT_DBG);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: one full instance at latency 1 plus
// port-0-only instances at latency 0 and 3, each with its own memory model.
module tb_data_mem_arbiter;

    localparam int NI = 3;
`ifdef DATA_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        int          port;
        int          cyc;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_clr;
    logic        req0 [NI];
    logic        req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        done0 [NI], done1 [NI], wen [NI], ren [NI];
    logic [31:0] rd0 [NI], rd1 [NI], waddr [NI], wdat [NI], raddr [NI], mrd [NI];

    int          n_chk = 0, n_pass = 0, cyc = 0;
    exp_t        sbq [$];
    exp_t        mon_e;
    logic [31:0] model_mem [int];
    logic [31:0] last_rd [2];

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (32'hA500_0000 ^ a);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (model_mem.exists(int'(a[9:2]))) return model_mem[int'(a[9:2])];
        return init_val(a);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        logic [31:0] mem      [256];
        logic        wr_valid [256];
        logic        s0v;
        logic [31:0] s0d;

        data_mem_arbiter #(.MEM_LATENCY(LAT)) u_dut (
            .clk                   (clk),
            .reset                 (reset),
            .Port0_req             (req0[g]),
            .Port0_we              (we0),
            .Port0_addr            (addr0),
            .Port0_wdata           (wdata0),
            .Port0_done            (done0[g]),
            .Port0_rdata           (rd0[g]),
            .Port1_req             ((g == 0) ? req1 : 1'b0),
            .Port1_we              (we1),
            .Port1_addr            (addr1),
            .Port1_wdata           (wdata1),
            .Port1_done            (done1[g]),
            .Port1_rdata           (rd1[g]),
            .Data_mem_write_enable (wen[g]),
            .Data_mem_write_addr   (waddr[g]),
            .Data_mem_write_data   (wdat[g]),
            .Data_mem_read_enable  (ren[g]),
            .Data_mem_read_addr    (raddr[g]),
            .Data_mem_read_data    (mrd[g])
        );

        always @(posedge clk) begin
            if (mem_clr) begin
                for (int i = 0; i < 256; i++) wr_valid[i] <= 1'b0;
            end else if (wen[g]) begin
                wr_valid[waddr[g][9:2]] <= 1'b1;
                mem[waddr[g][9:2]]      <= wdat[g];
            end
        end

        always_comb begin
            s0v = ren[g];
            s0d = wr_valid[raddr[g][9:2]] ? mem[raddr[g][9:2]] : init_val(raddr[g]);
        end

        // Memory drives valid data only in the cycle LAT after the read strobe.
        if (LAT == 0) begin : g_l0
            assign mrd[g] = s0v ? s0d : 32'hBAD0BAD0;
        end else begin : g_lp
            logic [LAT-1:0] pv;
            logic [31:0]    pd [LAT];
            always @(posedge clk) begin
                pv[0] <= s0v;
                pd[0] <= s0d;
                for (int k = 1; k < LAT; k++) begin
                    pv[k] <= pv[k-1];
                    pd[k] <= pd[k-1];
                end
            end
            assign mrd[g] = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0BAD0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic we,
                            input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            req0[0] = r; we0 = we; addr0 = a; wdata0 = wd;
        end else begin
            req1 = r; we1 = we; addr1 = a; wdata1 = wd;
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_wen",   32'(wen[0]),   0);
        chk("rst_ren",   32'(ren[0]),   0);
        chk("rst_done0", 32'(done0[0]), 0);
        chk("rst_done1", 32'(done1[0]), 0);
        chk("rst_rd0",   rd0[0],        0);
        chk("rst_rd1",   rd1[0],        0);
        chk("rst_waddr", waddr[0],      0);
        chk("rst_wdata", wdat[0],       0);
        chk("rst_raddr", raddr[0],      0);
    endtask

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (done0[0] || done1[0]) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", {30'b0, done1[0], done0[0]}, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("done_port", 32'(done1[0]), 32'(mon_e.port));
                chk("done_cyc", 32'(cyc), 32'(mon_e.cyc));
                chk("done_rdata", (mon_e.port == 1) ? rd1[0] : rd0[0], mon_e.rdata);
            end
        end
    end

    // One transaction on the main instance, starting from IDLE.
    task automatic run_one(input int p, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input bit hold);
        exp_t e;
        int   c0;
        bit   seen;
        tick();
        c0 = cyc;
        set_port(p, 1'b1, we, a, wd);
        e.port = p;
        e.cyc  = c0 + 3;
        if (we) begin
            model_mem[int'(a[9:2])] = wd;
            e.rdata = last_rd[p];
        end else begin
            e.rdata    = model_rd(a);
            last_rd[p] = e.rdata;
        end
        sbq.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            chk("rd_strobe", 32'(ren[0]), 32'(k == 1 && !we));
            chk("wr_strobe", 32'(wen[0]), 32'(k == 1 && we));
            if (k == 1) begin
                chk("strobe_addr", we ? waddr[0] : raddr[0], a);
                if (we) chk("strobe_wdata", wdat[0], wd);
            end
            seen = (p == 0) ? done0[0] : done1[0];
            if (!seen) begin
                tick();
                if (!hold) set_port(p, 1'b0, 1'b0, '0, '0);
            end
        end
        chk("done_seen", 32'(seen), 1);
        tick();
        set_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        exp_t e;
        int   c0, ndone, dc1, dc2;
        logic [31:0] v1, v2;

        reset = 1'b0; mem_clr = 1'b1; req1 = 1'b0;
        for (int i = 0; i < NI; i++) req0[i] = 1'b0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        last_rd[0] = '0; last_rd[1] = '0;
        repeat (3) tick();
        reset = 1'b1; mem_clr = 1'b0;
        @(negedge clk);
        chk_reset_state();

        run_one(0, 1'b0, 32'h100, '0, 1'b1);
        run_one(1, 1'b1, 32'h40, 32'h12345678, 1'b1);
        run_one(0, 1'b0, 32'h40, '0, 1'b0);
        run_one(1, 1'b0, 32'h300, '0, 1'b1);

        // Both ports hold req across three grants.
        tick();
        c0 = cyc;
        set_port(0, 1'b1, 1'b0, 32'h200, '0);
        set_port(1, 1'b1, 1'b0, 32'h304, '0);
        for (int i = 0; i < 3; i++) begin
            e.port  = RR ? (i % 2) : 0;
            e.cyc   = c0 + 3 + 4 * i;
            e.rdata = model_rd((e.port == 1) ? 32'h304 : 32'h200);
            last_rd[e.port] = e.rdata;
            sbq.push_back(e);
        end
        ndone = 0;
        for (int k = 0; k < 20 && ndone < 3; k++) begin
            @(negedge clk);
            if (done0[0] || done1[0]) ndone++;
            if (ndone < 3) tick();
        end
        chk("tie_done_count", 32'(ndone), 3);
        tick();
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);

        // Latency 0 and 3 instances, same read issued together.
        tick();
        c0 = cyc;
        we0 = 1'b0; addr0 = 32'h104;
        req0[1] = 1'b1; req0[2] = 1'b1;
        dc1 = -1; dc2 = -1; v1 = '0; v2 = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("l0_rd_strobe", 32'(ren[1]), 32'(k == 1));
            chk("l3_rd_strobe", 32'(ren[2]), 32'(k == 1));
            if (done0[1] && dc1 < 0) begin dc1 = cyc - c0; v1 = rd0[1]; end
            if (done0[2] && dc2 < 0) begin dc2 = cyc - c0; v2 = rd0[2]; end
            tick();
            if (dc1 >= 0) req0[1] = 1'b0;
            if (dc2 >= 0) req0[2] = 1'b0;
        end
        chk("l0_done_cyc", 32'(dc1), 2);
        chk("l3_done_cyc", 32'(dc2), 5);
        chk("l0_rdata", v1, model_rd(32'h104));
        chk("l3_rdata", v2, model_rd(32'h104));
        addr0 = '0;

        // Reset during WAIT aborts the access with no done.
        tick();
        set_port(0, 1'b1, 1'b0, 32'h108, '0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_port(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk_reset_state();
        last_rd[0] = '0; last_rd[1] = '0;
        repeat (3) tick();
        run_one(0, 1'b0, 32'h10C, '0, 1'b1);

        repeat (3) tick();
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
